// File: rtl/input_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : input_fifo                                                      |
// | Brief    : Router input-port buffer, show-ahead FIFO with full/empty flags.|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module input_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] Data_in,
  input  logic                  write,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] Data_out,
  input  logic                  read,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                 c_DEPTH      = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_FULL_COUNT = (ADDR_WIDTH+1)'(c_DEPTH);
  localparam logic [ADDR_WIDTH:0] c_ONE        = (ADDR_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_acc;
  logic                  w_rd_acc;

  assign w_full  = (r_count == c_FULL_COUNT);
  assign w_empty = (r_count == '0);

  // A read on a full FIFO frees a slot the same cycle, so the write may land.
  assign w_wr_acc = write & (~w_full | read);
  assign w_rd_acc = read & ~w_empty;

  // Storage has no reset; stale contents are hidden by the pointers/count.
  always_ff @(posedge clk) begin
    if (rst && w_wr_acc) begin
      r_mem[r_wr_ptr] <= Data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + c_ONE;
        2'b01:   r_count <= r_count - c_ONE;
        default: r_count <= r_count;
      endcase
      r_overflow  <= write & w_full & ~read;
      r_underflow <= read & w_empty;
    end
  end

  assign full      = w_full;
  assign empty     = w_empty;
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;
  assign Data_out  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: doc/input_fifo.md
Name: input_fifo

Overview:
- Per-port input buffer of the NoC router. It sits directly upstream of the input controller.
- It stores flits arriving from a neighbour router or the local core. Flit format is {data[7:4], y_des[3:2], x_des[1:0]}.
- It presents the oldest flit to the controller in show-ahead (first-word-fall-through) form, with the empty/read handshake the controller uses.
- It gives the upstream sender a full flag for backpressure.

Parameters:
- DATA_WIDTH, 8, flit width in bits.
- ADDR_WIDTH, 2, pointer width; depth = 2**ADDR_WIDTH = 4 entries.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
- Data_in  input  DATA_WIDTH  flit from the upstream link.
- write  input  1  upstream write strobe; one flit per cycle while high.
- full  output  1  high when the FIFO holds 2**ADDR_WIDTH flits.
- Data_out  output  DATA_WIDTH  oldest stored flit, show-ahead; feeds the controller Data_in.
- read  input  1  pop strobe from the controller.
- empty  output  1  high when the FIFO holds 0 flits; feeds the controller empty.
- count  output  ADDR_WIDTH+1  number of stored flits, 0..2**ADDR_WIDTH.
- overflow  output  1  one-cycle pulse when a write is dropped.
- underflow  output  1  one-cycle pulse when a read is ignored.

Behaviour:
- Storage: 2**ADDR_WIDTH x DATA_WIDTH register array.
  - wr_ptr and rd_ptr are ADDR_WIDTH bits wide and wrap naturally from 3 to 0.
  - count is a separate ADDR_WIDTH+1-bit counter.
- Reset (rst==0 at a rising edge):
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - Resulting outputs: empty = 1, full = 0, overflow = 0, underflow = 0.
  - Memory contents are not cleared. Data_out is don't-care while empty.
  - Reset overrides write/read in the same cycle. A reset mid-stream discards all stored flits.
- Flags:
  - empty = (count == 0) and full = (count == 2**ADDR_WIDTH), both decoded from the registered count.
  - Data_out = mem[rd_ptr], combinational from registered state, so there is no read latency.
  - A flit written at edge N is visible on Data_out, with empty = 0, after edge N when the FIFO was previously empty.
- Write accept: wr_acc = write & (~full | read).
  - On accept: mem[wr_ptr] <= Data_in and wr_ptr <= wr_ptr + 1.
- Read accept: rd_acc = read & ~empty.
  - On accept: rd_ptr <= rd_ptr + 1.
  - The flit shown on Data_out during the read cycle is the one consumed.
- count update:
  - +1 on wr_acc only.
  - -1 on rd_acc only.
  - Unchanged when both or neither are accepted.
- Simultaneous write and read:
  - When the FIFO is non-empty and not full, both are accepted; count is unchanged.
  - When full and read = 1, both are accepted: the slot freed by the read is reused the same cycle, and full stays 1.
  - When empty and read = 1, only the write is accepted. The flit is not bypassed to Data_out; it appears next cycle. underflow pulses.
- Error pulses, registered and high for exactly the cycle after the event:
  - overflow <= write & full & ~read.
  - underflow <= read & empty.
  - The dropped write or ignored read has no other effect on state.
- No combinational path from read or write to full, empty or count.

Test Plan:
- Reset then idle: drive rst = 0 for 2 cycles, then rst = 1 -> empty = 1, full = 0, count = 0, overflow = 0, underflow = 0.
- Single flit: write 8'b00000110 for 1 cycle -> next cycle empty = 0, count = 1, Data_out = 8'h06. Assert read 1 cycle -> next cycle empty = 1, count = 0.
- Fill and overflow:
  - Write 8'h07, 8'h0E, 8'h16, 8'h1B on consecutive cycles -> full = 1, count = 4.
  - A 5th write of 8'hFF with read = 0 -> overflow pulses 1 cycle; contents unchanged.
  - Draining with read held high 4 cycles -> Data_out shows 07, 0E, 16, 1B in order, then empty = 1.
- Full with simultaneous read/write: with the FIFO full of 8'h01..8'h04, write 8'h05 and read together -> count stays 4 and full stays 1. Drain order is 02, 03, 04, 05, which checks pointer wrap.
- Underflow: on an empty FIFO, assert read alone -> underflow pulses 1 cycle and count stays 0. Assert read and write 8'h0A together -> underflow pulses and the next cycle shows count = 1, Data_out = 8'h0A.
- Reset mid-operation: with 3 flits stored, pull rst = 0 for 1 cycle while write = 1 -> next cycle empty = 1, count = 0, and the flit written during reset is not stored.
